// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter holding register.
// The producer offers data with in_valid; the transmitter accepts when in_ready is high.
interface uart_tx_if;
  logic       in_valid;
  logic [7:0] data;
  logic       in_ready;

  modport master (output in_valid, output data, input in_ready);
  modport slave  (input in_valid, input data, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: a one-byte holding register feeds a shifter, and TX is sent LSB first.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  uart_tx_if.slave   bus,
  output logic       TX,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shifter, shifter_d;
  logic [7:0]       hold, hold_d;
  logic             hold_valid, hold_valid_d;
  logic             tx_d;
  logic             load;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity, parity_d;
`endif

  assign bus.in_ready = ~hold_valid;
  assign bit_end      = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      TX         <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shifter    <= shifter_d;
      hold       <= hold_d;
      hold_valid <= hold_valid_d;
      TX         <= tx_d;
      busy       <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      parity     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    shifter_d    = shifter;
    hold_d       = hold;
    hold_valid_d = hold_valid;
    load         = 1'b0;
    tx_d         = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity;
`endif

    case (state)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        load  = hold_valid & enable;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d     = '0;
          shifter_d = {1'b0, shifter[7:1]};
          if (idx == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx == STOP_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
            load    = hold_valid & enable;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading the shifter overrides the return to IDLE so back-to-back frames have no gap.
    if (load) begin
      shifter_d    = hold;
      hold_valid_d = 1'b0;
      state_d      = START;
      cnt_d        = '0;
      idx_d        = '0;
`ifdef UART_TX_PARITY_EN
      parity_d     = ^hold;
`endif
    end

    if (bus.in_valid && !hold_valid) begin
      hold_d       = bus.data;
      hold_valid_d = 1'b1;
    end

    // TX is registered, so it is derived from where the FSM will be after this edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a default instance (16x, 1 stop) and an 8x, 2-stop instance,
// checked cycle by cycle against a bit-slot model of the UART frame.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         par;
  } vec_t;

  logic clk;
  logic reset;
  logic enable1, enable2;
  logic tx1, tx2, busy1, busy2;
  int   total;
  int   bad;

  uart_tx_if bus1();
  uart_tx_if bus2();

  uart_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .bus(bus1), .TX(tx1), .busy(busy1)
  );

  uart_tx #(.OVERSAMPLE(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .bus(bus2), .TX(tx2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic txOf(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? bus1.in_ready : bus2.in_ready;
  endfunction

  task automatic setIn(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus1.in_valid = v;
      bus1.data     = d;
    end else begin
      bus2.in_valid = v;
      bus2.data     = d;
    end
  endtask

  // Reference: line value of bit slot s of a frame carrying byte b.
  function automatic bit slotBit(input logic [7:0] b, input int s);
    if (s == 0) return 1'b0;
    if (s <= 8) return bit'((int'(b) / (1 << (s - 1))) % 2);
    if (PAR == 1 && s == 9) return bit'($countones(b) % 2);
    return 1'b1;
  endfunction

  function automatic void modelFrames(input logic [7:0] bytes[$], input int sb, output bit q[$]);
    q = {};
    foreach (bytes[k])
      for (int s = 0; s < 9 + PAR + sb; s++) q.push_back(slotBit(bytes[k], s));
  endfunction

  // Holds in_valid and walks the byte list, advancing whenever the DUT was ready at the edge.
  task automatic driveBytes(input int sel, input logic [7:0] bytes[$]);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    setIn(sel, 1'b1, bytes[0]);
    while (i < bytes.size() && guard < 4000) begin
      rdy = readyOf(sel);
      @(negedge clk);
      guard++;
      if (rdy === 1'b1) begin
        i++;
        if (i < bytes.size()) setIn(sel, 1'b1, bytes[i]);
        else                  setIn(sel, 1'b0, bytes[i-1]);
      end
    end
    if (i < bytes.size()) begin
      checkOutput("drive_timeout", i, bytes.size());
      setIn(sel, 1'b0, 8'h00);
    end
  endtask

  task automatic runWave(input int sel, input string name, input int lead,
                         input int nFrames, input bit slots[$]);
    int os  = (sel == 0) ? 16 : 8;
    int spf = slots.size() / nFrames;
    int err;
    err = 0;
    for (int c = 0; c < lead; c++) begin
      @(negedge clk);
      if (txOf(sel) !== 1'b1 || busyOf(sel) !== 1'b0) err++;
    end
    if (lead > 0) checkOutput({name, "_lead"}, err, 0);
    for (int f = 0; f < nFrames; f++) begin
      err = 0;
      for (int s = 0; s < spf; s++)
        for (int c = 0; c < os; c++) begin
          @(negedge clk);
          if (txOf(sel) !== slots[f*spf + s] || busyOf(sel) !== 1'b1) err++;
        end
      checkOutput($sformatf("%s_frame%0d", name, f), err, 0);
    end
    @(negedge clk);
    checkOutput({name, "_end_idle"}, int'(txOf(sel) !== 1'b1 || busyOf(sel) !== 1'b0), 0);
  endtask

  task automatic sendWave(input int sel, input string name, input logic [7:0] bytes[$]);
    bit q[$];
    modelFrames(bytes, (sel == 0) ? 1 : 2, q);
    fork
      driveBytes(sel, bytes);
      runWave(sel, name, 1, bytes.size(), q);
    join
  endtask

  task automatic applyStimulus(input vec_t v);
    bit         q[$];
    logic [7:0] one[$];
    q = {};
    for (int s = 0; s <= 8; s++) q.push_back(v.frame[s]);
    if (PAR == 1) q.push_back(v.par);
    q.push_back(v.frame[9]);
    one = {v.data};
    fork
      driveBytes(0, one);
      runWave(0, $sformatf("tbl_%02h", v.data), 1, 1, q);
    join
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t       tbl[9];
    logic [7:0] q8[$];
    bit         q[$];
    int         err;

    tbl[0] = '{8'h55, 10'h2AA, 1'b0};
    tbl[1] = '{8'h00, 10'h200, 1'b0};
    tbl[2] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[3] = '{8'hA5, 10'h34A, 1'b0};
    tbl[4] = '{8'h3C, 10'h278, 1'b0};
    tbl[5] = '{8'h81, 10'h302, 1'b0};
    tbl[6] = '{8'h07, 10'h20E, 1'b1};
    tbl[7] = '{8'h03, 10'h206, 1'b0};
    tbl[8] = '{8'h80, 10'h300, 1'b1};

    total = 0;
    bad   = 0;
    reset = 1'b1;
    enable1 = 1'b0;
    enable2 = 1'b0;
    setIn(0, 1'b0, 8'h00);
    setIn(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_tx1",    int'(tx1), 1);
    checkOutput("rst_busy1",  int'(busy1), 0);
    checkOutput("rst_ready1", int'(bus1.in_ready), 1);
    checkOutput("rst_tx2",    int'(tx2), 1);
    checkOutput("rst_busy2",  int'(busy2), 0);
    checkOutput("rst_ready2", int'(bus2.in_ready), 1);

    // Disabled transmitter still accepts a byte but must not start sending it.
    setIn(0, 1'b1, 8'h3C);
    @(negedge clk);
    setIn(0, 1'b0, 8'h00);
    checkOutput("dis_ready_low", int'(bus1.in_ready), 0);
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) err++;
    end
    checkOutput("dis_idle", err, 0);
    enable1 = 1'b1;
    modelFrames('{8'h3C}, 1, q);
    runWave(0, "en_raise", 0, 1, q);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    sendWave(0, "stream3", '{8'h00, 8'hFF, 8'hA5});

    q8 = {};
    repeat (8) q8.push_back(8'($urandom));
    sendWave(0, "rand_stream", q8);
    repeat (6) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sendWave(0, "rand_single", '{8'($urandom)});
    end

    // Enable dropped mid-frame: current frame completes, held byte waits for enable.
    modelFrames('{8'hA5}, 1, q);
    fork
      runWave(0, "en_drop", 1, 1, q);
      begin
        driveBytes(0, '{8'hA5, 8'h5A});
        repeat (40) @(negedge clk);
        enable1 = 1'b0;
      end
    join
    err = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) err++;
    end
    checkOutput("en_drop_wait", err, 0);
    checkOutput("en_drop_held", int'(bus1.in_ready), 0);
    enable1 = 1'b1;
    modelFrames('{8'h5A}, 1, q);
    runWave(0, "en_resume", 0, 1, q);

    // Junk offered while the holding register is full must not replace the held byte.
    modelFrames('{8'h96, 8'h4B}, 1, q);
    fork
      runWave(0, "hold_guard", 1, 2, q);
      begin
        driveBytes(0, '{8'h96, 8'h4B});
        repeat (20) begin
          setIn(0, 1'b1, 8'($urandom));
          @(negedge clk);
        end
        setIn(0, 1'b0, 8'h00);
      end
    join

    // Reset mid-frame with a byte held and a new offer in the same cycle.
    driveBytes(0, '{8'h81, 8'h5A});
    repeat (67) @(negedge clk);
    checkOutput("rst_mid_bit", int'(tx1), int'(slotBit(8'h81, 68 / 16)));
    reset = 1'b1;
    setIn(0, 1'b1, 8'hEE);
    @(negedge clk);
    reset = 1'b0;
    setIn(0, 1'b0, 8'h00);
    checkOutput("rst_mid_tx",    int'(tx1), 1);
    checkOutput("rst_mid_busy",  int'(busy1), 0);
    checkOutput("rst_mid_ready", int'(bus1.in_ready), 1);
    err = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || bus1.in_ready !== 1'b1) err++;
    end
    checkOutput("rst_no_frame", err, 0);

    enable2 = 1'b1;
    sendWave(1, "os8_sb2_C3", '{8'hC3});
    sendWave(1, "os8_sb2_stream", '{8'($urandom), 8'($urandom), 8'($urandom)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, clk cycles per bit period; legal range 4..64.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 Port clk  input  1  clock, 16 x baudrate at default OVERSAMPLE; all logic on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port enable  input  1  transmitter enable; gates only the start of new frames.
REQ-006 Port in_valid  input  1  byte on data is offered.
REQ-007 Port data  input  8  byte to transmit, LSB first.
REQ-008 Port in_ready  output  1  holding register empty; a byte is accepted when in_valid & in_ready.
REQ-009 Port TX  output  1  UART transmit line, idle high, registered output.
REQ-010 Port busy  output  1  high from the first start-bit cycle to the last stop-bit cycle.

Function
REQ-011 The block SHALL use a one-byte holding register plus a shift register.
- Accepted byte goes to the holding register; in_ready deasserts on the next edge.
REQ-012 The block SHALL implement the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
REQ-013 IDLE: if the holding register is full and enable=1, the block SHALL copy the holding register into the shifter, empty the holding register (in_ready=1 next cycle), and enter START.
REQ-014 A byte accepted while IDLE with enable=1 SHALL drive TX low on the second edge after acceptance: one edge to load holding, one to start.
REQ-015 Each bit SHALL last exactly OVERSAMPLE clk cycles, timed by a bit-cycle counter cleared on every bit boundary.
REQ-016 The 8 data bits SHALL be sent data[0] first, then STOP_BITS stop bits at TX=1.
REQ-017 Frame length SHALL be (10+STOP_BITS-1)*OVERSAMPLE cycles: 160 at default, plus OVERSAMPLE when parity is compiled in.
REQ-018 At the end of the last stop bit, if the holding register is full and enable=1, the block SHALL go directly to START on the same edge.
- No idle cycle between frames; busy stays high.
REQ-019 The holding register SHALL accept a new byte while a frame is in progress, so back-to-back streaming is gapless.
REQ-020 If in_valid=1 while in_ready=0, the offered byte SHALL be neither accepted nor corrupted.
REQ-021 If enable=0 mid-frame, the block SHALL finish the current frame and then wait in IDLE with TX=1, keeping any held byte.
REQ-022 busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set TX=1, busy=0, in_ready=1, FSM=IDLE, and clear both counters and the holding-valid flag.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (TX=1 on the next edge) and discard the held byte.
REQ-025 Reset SHALL take priority over in_valid and enable in the same cycle.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: one PARITY bit (even parity = XOR of the 8 data bits) SHALL be sent between the last data bit and the stop bits.
REQ-027 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent and the frame SHALL be start+8 data+stop bits.

Verification
REQ-028 Reset, enable=1, one-cycle in_valid with data=0x55 -> TX low 16 cycles, then alternating 1,0,... each held 16 cycles LSB first, then stop high 16; busy high exactly 160 cycles.
REQ-029 Stream 0x00,0xFF,0xA5 with in_valid held and obeying in_ready -> three contiguous frames, no idle gap, busy high 480 cycles, decoded bytes match.
REQ-030 enable=0, offer 0x3C -> byte accepted, TX stays 1, busy=0; raise enable -> frame starts one edge later.
REQ-031 reset pulsed at cycle 70 of a 0x81 frame -> TX=1 and busy=0 next cycle; in_ready=1; no further frame without a new byte.
REQ-032 UART_TX_PARITY_EN defined, data=0x07 -> parity bit=1, frame 176 cycles; data=0x03 -> parity bit=0.
REQ-033 STOP_BITS=2, OVERSAMPLE=8, data=0xC3 -> stop high 16 cycles, frame 88 cycles.
